// File: rtl/fft_iter_sched.sv
// fft_iter_sched: butterfly scheduler for an in-place iterative radix-2 DIT FFT.
// Walks AWL stages x N/2 butterflies issuing read, launch and write-back per butterfly.
module fft_iter_sched #(
  parameter int AWL           = 5,
  parameter int SWL           = 3,
  parameter int BUT_CLK_CYCLE = 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic           START,
  output logic           o_RD,
  output logic [AWL-1:0] o_A_ADDR,
  output logic [AWL-1:0] o_B_ADDR,
  output logic [AWL-2:0] o_TW_ADDR,
  output logic           o_BUT_START,
  output logic           o_WR,
  output logic [SWL-1:0] o_STAGE,
  output logic           o_RAM_BLOCK,
  output logic           o_DONE
);
  localparam int CW = (BUT_CLK_CYCLE > 1) ? $clog2(BUT_CLK_CYCLE) : 1;
  localparam logic [SWL-1:0] SMAX = SWL'(AWL - 1);
  localparam logic [AWL-2:0] JMAX = '1;
  localparam logic [CW-1:0]  CMAX = CW'(BUT_CLK_CYCLE - 1);

  typedef enum logic [2:0] {IDLE, RD, CALC, WR, DONE} state_t;

  state_t         state_q, state_d;
  logic [SWL-1:0] s_q, s_d;
  logic [AWL-2:0] j_q, j_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AWL-1:0] a_q, a_d, b_q, b_d;
  logic [AWL-2:0] tw_q, tw_d;
  logic           load;
  logic [AWL-1:0] half, msk, jw;

  // Addresses are recomputed only when a new butterfly is loaded, so they hold through RD/CALC/WR.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    if (EN)
      case (state_q)
        IDLE: if (START) begin
          state_d = RD;
          s_d     = '0;
          j_d     = '0;
          load    = 1'b1;
        end
        RD: begin
          state_d = CALC;
          cnt_d   = '0;
        end
        CALC: if (cnt_q == CMAX) state_d = WR;
              else cnt_d = cnt_q + CW'(1);
        WR: begin
          load    = (j_q != JMAX) || (s_q != SMAX);
          state_d = load ? RD : DONE;
          j_d     = j_q + (AWL-1)'(1);
          s_d     = (j_q == JMAX && s_q != SMAX) ? s_q + SWL'(1) : s_q;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    half = AWL'(1) << s_d;
    msk  = half - AWL'(1);
    jw   = AWL'(j_d);
    a_d  = load ? (((jw & ~msk) << 1) | (jw & msk)) : a_q;
    b_d  = load ? (((jw & ~msk) << 1) | (jw & msk) | half) : b_q;
    tw_d = load ? (j_d << (SMAX - s_d)) : tw_q;
  end

  always_ff @(posedge CLK)
    if (!RST) begin
      state_q <= IDLE;
      s_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tw_q    <= tw_d;
    end

  assign o_RD        = EN && state_q == RD;
  assign o_BUT_START = EN && state_q == CALC && cnt_q == '0;
  assign o_WR        = EN && state_q == WR;
  assign o_DONE      = EN && state_q == DONE;
  assign o_RAM_BLOCK = state_q == RD || state_q == CALC || state_q == WR;
  assign o_A_ADDR    = a_q;
  assign o_B_ADDR    = b_q;
  assign o_TW_ADDR   = tw_q;
  assign o_STAGE     = s_q;
endmodule

// File: tb/tb_fft_iter_sched.sv
// tb_fft_iter_sched: directed checks of the FFT butterfly scheduler at AWL=3 and AWL=5.
module tb_fft_iter_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst3, en3, start3, rd3, bs3, wr3, blk3, done3;
  logic [2:0] a3, b3, st3;
  logic [1:0] tw3;
  logic rst5, en5, start5, rd5, bs5, wr5, blk5, done5;
  logic [4:0] a5, b5;
  logic [3:0] tw5;
  logic [2:0] st5;

  fft_iter_sched #(.AWL(3), .SWL(3), .BUT_CLK_CYCLE(2)) dut3 (
    .CLK(clk), .RST(rst3), .EN(en3), .START(start3), .o_RD(rd3), .o_A_ADDR(a3), .o_B_ADDR(b3),
    .o_TW_ADDR(tw3), .o_BUT_START(bs3), .o_WR(wr3), .o_STAGE(st3), .o_RAM_BLOCK(blk3), .o_DONE(done3));
  fft_iter_sched #(.AWL(5), .SWL(3), .BUT_CLK_CYCLE(2)) dut5 (
    .CLK(clk), .RST(rst5), .EN(en5), .START(start5), .o_RD(rd5), .o_A_ADDR(a5), .o_B_ADDR(b5),
    .o_TW_ADDR(tw5), .o_BUT_START(bs5), .o_WR(wr5), .o_STAGE(st5), .o_RAM_BLOCK(blk5), .o_DONE(done5));

  int rd_n = 0, wr_n = 0, bs_n = 0, blk_n = 0, done_n = 0, both_n = 0, log_n = 0;
  int log_a[256], log_b[256], log_tw[256], log_s[256];
  int last_a5 = 0, last_b5 = 0, last_tw5 = 0, last_s5 = 0;

  always @(negedge clk) begin
    if (rd3) rd_n++;
    if (wr3) wr_n++;
    if (bs3) bs_n++;
    if (blk3) blk_n++;
    if (done3) done_n++;
    if (done3 && blk3) both_n++;
    if (wr3 && log_n < 256) begin
      log_a[log_n] = int'(a3);
      log_b[log_n] = int'(b3);
      log_tw[log_n] = int'(tw3);
      log_s[log_n] = int'(st3);
      log_n++;
    end
    if (wr5) begin
      last_a5 = int'(a5);
      last_b5 = int'(b5);
      last_tw5 = int'(tw5);
      last_s5 = int'(st5);
    end
  end

  int exp_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  int exp_s[12]  = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done3(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done3) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic chk_log(input string tag, input int base);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("%s_wr%0d_a", tag, i), log_a[base+i], exp_a[i]);
      chk($sformatf("%s_wr%0d_b", tag, i), log_b[base+i], exp_b[i]);
      chk($sformatf("%s_wr%0d_tw", tag, i), log_tw[base+i], exp_tw[i]);
      chk($sformatf("%s_wr%0d_s", tag, i), log_s[base+i], exp_s[i]);
    end
  endtask

  int t_acc, at, at1, base, found, rd0, wr0, bs0, blk0, dn0;

  initial begin
    rst3 = 1'b0; en3 = 1'b1; start3 = 1'b0;
    rst5 = 1'b0; en5 = 1'b1; start5 = 1'b0;
    tick;
    tick;
    @(negedge clk);
    chk("rst_strobes", int'({rd3, wr3, bs3, done3, blk3}), 0);
    chk("rst_a", int'(a3), 0);
    chk("rst_b", int'(b3), 0);
    chk("rst_tw", int'(tw3), 0);
    chk("rst_stage", int'(st3), 0);
    tick;
    rst3 = 1'b1;
    tick;

    base = log_n; rd0 = rd_n; wr0 = wr_n; bs0 = bs_n; blk0 = blk_n; dn0 = done_n;
    start3 = 1'b1;
    tick;
    t_acc = cyc;
    start3 = 1'b0;
    wait_done3(100, at);
    chk("run1_done_seen", (at >= 0) ? 1 : 0, 1);
    chk("run1_latency", at - t_acc + 1, 49);
    tick;
    chk("run1_rd_count", rd_n - rd0, 12);
    chk("run1_wr_count", wr_n - wr0, 12);
    chk("run1_bs_count", bs_n - bs0, 12);
    chk("run1_blk_cycles", blk_n - blk0, 48);
    chk("run1_done_count", done_n - dn0, 1);
    chk_log("run1", base);

    base = log_n; rd0 = rd_n;
    start3 = 1'b1;
    tick;
    t_acc = cyc;
    wait_done3(100, at);
    chk("held_latency", at - t_acc + 1, 49);
    chk("held_rd_count", rd_n - rd0, 12);
    at1 = at;
    @(negedge clk);
    chk("held_idle_blk", int'(blk3), 0);
    @(negedge clk);
    chk("held_restart_rd", int'(rd3), 1);
    chk("held_restart_a", int'(a3), 0);
    chk("held_restart_b", int'(b3), 1);
    wait_done3(100, at);
    start3 = 1'b0;
    chk("held_done_gap", at - at1, 50);
    tick;
    chk_log("held2", base + 12);

    tick;
    rd0 = rd_n; wr0 = wr_n; bs0 = bs_n;
    start3 = 1'b1;
    tick;
    t_acc = cyc;
    start3 = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd3 && st3 == 3'd1 && a3 == 3'd4) begin
        found = 1;
        break;
      end
    end
    chk("frz_found", found, 1);
    tick;
    en3 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("frz%0d_strobes", i), int'({rd3, wr3, bs3, done3}), 0);
      chk($sformatf("frz%0d_a", i), int'(a3), 4);
      chk($sformatf("frz%0d_b", i), int'(b3), 6);
      tick;
    end
    en3 = 1'b1;
    wait_done3(120, at);
    chk("frz_latency", at - t_acc + 1, 56);
    tick;
    chk("frz_rd_count", rd_n - rd0, 12);
    chk("frz_bs_count", bs_n - bs0, 12);
    chk("frz_wr_count", wr_n - wr0, 12);

    tick;
    start3 = 1'b1;
    tick;
    start3 = 1'b0;
    dn0 = done_n;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr3 && st3 == 3'd2 && a3 == 3'd1) begin
        found = 1;
        break;
      end
    end
    chk("abort_found", found, 1);
    chk("abort_wr_b", int'(b3), 5);
    rst3 = 1'b0;
    @(negedge clk);
    chk("abort_strobes", int'({rd3, wr3, bs3, done3, blk3}), 0);
    chk("abort_a", int'(a3), 0);
    chk("abort_b", int'(b3), 0);
    chk("abort_tw", int'(tw3), 0);
    chk("abort_stage", int'(st3), 0);
    tick;
    wr0 = wr_n;
    rst3 = 1'b1;
    repeat (8) tick;
    chk("abort_no_wr", wr_n - wr0, 0);
    chk("abort_no_done", done_n - dn0, 0);
    start3 = 1'b1;
    tick;
    start3 = 1'b0;
    @(negedge clk);
    chk("restart_rd", int'(rd3), 1);
    chk("restart_blk", int'(blk3), 1);
    chk("restart_a", int'(a3), 0);
    chk("restart_b", int'(b3), 1);
    chk("restart_stage", int'(st3), 0);

    tick;
    rst5 = 1'b1;
    tick;
    start5 = 1'b1;
    tick;
    t_acc = cyc;
    start5 = 1'b0;
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done5) begin
        at = cyc;
        break;
      end
    end
    chk("awl5_latency", at - t_acc + 1, 321);
    tick;
    chk("awl5_last_a", last_a5, 15);
    chk("awl5_last_b", last_b5, 31);
    chk("awl5_last_tw", last_tw5, 15);
    chk("awl5_last_stage", last_s5, 4);
    chk("done_blk_overlap", both_n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
